// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS-subset control unit: sequences fetch/decode/execute/memory/
// writeback, decodes the opcode into per-state datapath controls, counts retired and illegal instructions.
module mc_ctrl_unit #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               PC_en_o,
  output logic               IorD_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               IRWrite_o,
  output logic               MemtoReg_o,
  output logic [1:0]         PCSource_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic               RegWrite_o,
  output logic               RegDst_o,
  output logic [3:0]         state_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   retired_o,
  output logic [CNT_W-1:0]   illegal_cnt_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_R     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  localparam logic [ALUOP_W-1:0] ALU_R     = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_BEQ   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLTIU = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_ORI   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(6);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;
  logic               retire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_FETCH;
      retired_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      retired_q     <= retired_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_cnt_d = illegal_cnt_q;
    retire        = 1'b0;
    PC_en_o       = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    PCSource_o    = 2'b00;
    ALU_op_o      = ALU_R;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    RegWrite_o    = 1'b0;
    RegDst_o      = 1'b0;
    illegal_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        ALU_op_o  = ALU_ADD;
        IRWrite_o = mem_ready_i;
        PC_en_o   = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB_o = 2'b11;
        ALU_op_o  = ALU_ADD;
        if (instr_op_i == OP_R)
          state_d = S_R_EXEC;
        else if (instr_op_i == OP_LW || instr_op_i == OP_SW)
          state_d = S_MEM_ADDR;
        else if (instr_op_i == OP_BEQ || instr_op_i == OP_BNE)
          state_d = S_BRANCH;
        else if (instr_op_i == OP_ADDI || instr_op_i == OP_SLTIU ||
                 instr_op_i == OP_ORI  || instr_op_i == OP_LUI)
          state_d = S_I_EXEC;
        else if (EN_JUMP && instr_op_i == OP_J)
          state_d = S_JUMP;
        else
          state_d = S_ILLEGAL;
      end
      S_R_EXEC: begin
        ALUSrcA_o = 1'b1;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        case (instr_op_i)
          OP_SLTIU: ALU_op_o = ALU_SLTIU;
          OP_ORI:   ALU_op_o = ALU_ORI;
          OP_LUI:   ALU_op_o = ALU_LUI;
          default:  ALU_op_o = ALU_ADD;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALU_op_o  = ALU_ADD;
        state_d   = (instr_op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUSrcA_o  = 1'b1;
        PCSource_o = 2'b01;
        if (instr_op_i == OP_BEQ) begin
          ALU_op_o = ALU_BEQ;
          PC_en_o  = zero_i;
        end else begin
          ALU_op_o = ALU_BNE;
          PC_en_o  = ~zero_i;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCSource_o = 2'b10;
        PC_en_o    = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        // PC was already advanced in FETCH, so the instruction is simply skipped.
        illegal_o     = 1'b1;
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  assign state_o       = state_q;
  assign retired_o     = retired_q;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: per-cycle vector table checked through an expected queue,
// plus counter checks; a second instance (EN_JUMP=0, CNT_W=4) shares the inputs.
module tb_mc_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       ready;

  logic        pc_en, iord, mem_rd, mem_wr, ir_wr, mem2reg, alu_a, reg_wr, reg_dst, ill;
  logic [1:0]  pc_src, alu_b;
  logic [2:0]  alu_op;
  logic [3:0]  st;
  logic [31:0] retired, ill_cnt;

  logic        d2_pc_en, d2_iord, d2_mem_rd, d2_mem_wr, d2_ir_wr, d2_mem2reg;
  logic        d2_alu_a, d2_reg_wr, d2_reg_dst, d2_ill;
  logic [1:0]  d2_pc_src, d2_alu_b;
  logic [2:0]  d2_alu_op;
  logic [3:0]  d2_st;
  logic [3:0]  d2_retired, d2_ill_cnt;

  always #5 clk = ~clk;

  mc_ctrl_unit dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .zero_i(zero), .mem_ready_i(ready),
    .PC_en_o(pc_en), .IorD_o(iord), .MemRead_o(mem_rd), .MemWrite_o(mem_wr),
    .IRWrite_o(ir_wr), .MemtoReg_o(mem2reg), .PCSource_o(pc_src), .ALU_op_o(alu_op),
    .ALUSrcA_o(alu_a), .ALUSrcB_o(alu_b), .RegWrite_o(reg_wr), .RegDst_o(reg_dst),
    .state_o(st), .illegal_o(ill), .retired_o(retired), .illegal_cnt_o(ill_cnt)
  );

  mc_ctrl_unit #(.CNT_W(4), .EN_JUMP(1'b0)) dut2 (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .zero_i(zero), .mem_ready_i(ready),
    .PC_en_o(d2_pc_en), .IorD_o(d2_iord), .MemRead_o(d2_mem_rd), .MemWrite_o(d2_mem_wr),
    .IRWrite_o(d2_ir_wr), .MemtoReg_o(d2_mem2reg), .PCSource_o(d2_pc_src),
    .ALU_op_o(d2_alu_op), .ALUSrcA_o(d2_alu_a), .ALUSrcB_o(d2_alu_b),
    .RegWrite_o(d2_reg_wr), .RegDst_o(d2_reg_dst), .state_o(d2_st), .illegal_o(d2_ill),
    .retired_o(d2_retired), .illegal_cnt_o(d2_ill_cnt)
  );

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       ready;
    logic [3:0] st;
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          vec_idx = 0;
  int          d2_pulses = 0;

  // Expected controls for a given state and inputs, taken from the per-state table.
  function automatic logic [20:0] model(logic [3:0] s, logic [5:0] o, logic z, logic r);
    logic m_pc_en, m_iord, m_rd, m_wr, m_ir, m_m2r, m_a, m_rw, m_dst, m_ill;
    logic [1:0] m_src, m_b;
    logic [2:0] m_op;
    {m_pc_en, m_iord, m_rd, m_wr, m_ir, m_m2r, m_a, m_rw, m_dst, m_ill} = '0;
    m_src = 2'b00; m_b = 2'b00; m_op = 3'b000;
    case (s)
      4'd0:  begin m_rd = 1; m_b = 2'b01; m_op = 3'b011; m_pc_en = r; m_ir = r; end
      4'd1:  begin m_b = 2'b11; m_op = 3'b011; end
      4'd2:  begin m_a = 1; end
      4'd3:  begin m_rw = 1; m_dst = 1; end
      4'd4:  begin
        m_a = 1; m_b = 2'b10;
        m_op = (o == 6'd9) ? 3'b100 : (o == 6'd13) ? 3'b101 : (o == 6'd15) ? 3'b110 : 3'b011;
      end
      4'd5:  begin m_rw = 1; end
      4'd6:  begin m_a = 1; m_b = 2'b10; m_op = 3'b011; end
      4'd7:  begin m_rd = 1; m_iord = 1; end
      4'd8:  begin m_rw = 1; m_m2r = 1; end
      4'd9:  begin m_wr = 1; m_iord = 1; end
      4'd10: begin
        m_a = 1; m_src = 2'b01;
        m_op = (o == 6'd4) ? 3'b001 : 3'b010;
        m_pc_en = (o == 6'd4) ? z : ~z;
      end
      4'd11: begin m_src = 2'b10; m_pc_en = 1; end
      4'd12: begin m_ill = 1; end
      default: ;
    endcase
    return {m_pc_en, m_iord, m_rd, m_wr, m_ir, m_m2r, m_src, m_op, m_a, m_b, m_rw, m_dst, m_ill, s};
  endfunction

  function automatic void add(logic r, int o, logic z, logic rdy, int s);
    vec_t v;
    v.rst = r; v.op = 6'(o); v.zero = z; v.ready = rdy; v.st = 4'(s);
    vecs.push_back(v);
  endfunction

  function automatic void add_seq(int o, logic z, int path[]);
    foreach (path[i]) add(1'b0, o, z, 1'b1, path[i]);
  endfunction

  task automatic run_vec(vec_t v);
    logic [20:0] got, exp;
    @(negedge clk);
    rst = v.rst; op = v.op; zero = v.zero; ready = v.ready;
    exp_q.push_back(model(v.st, v.op, v.zero, v.ready));
    #1;
    got = {pc_en, iord, mem_rd, mem_wr, ir_wr, mem2reg, pc_src, alu_op, alu_a, alu_b,
           reg_wr, reg_dst, ill, st};
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL vec%0d ctrl: got=%06h exp=%06h (state got=%0d exp=%0d)",
               vec_idx, got, exp, st, v.st);
    end
    d2_pulses += int'(d2_ill);
    vec_idx++;
  endtask

  task automatic run_all();
    while (vecs.size() > 0) run_vec(vecs.pop_front());
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; op = '0; zero = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then R, addi, lw, sw with no wait states (17 cycles).
    add(1'b0, 0, 1'b0, 1'b0, 0);
    add_seq(0,  1'b0, '{0, 1, 2, 3});
    add_seq(8,  1'b0, '{0, 1, 4, 5});
    add_seq(35, 1'b0, '{0, 1, 6, 7, 8});
    add_seq(43, 1'b0, '{0, 1, 6, 9});
    add(1'b0, 0, 1'b0, 1'b0, 0);
    run_all();
    check("retired_after_4", retired, 4);
    check("illcnt_after_4", ill_cnt, 0);

    // lw with 3 wait cycles in FETCH and 2 in MEM_READ (10 cycles).
    add(1'b0, 35, 1'b0, 1'b0, 0);
    add(1'b0, 35, 1'b0, 1'b0, 0);
    add(1'b0, 35, 1'b0, 1'b0, 0);
    add(1'b0, 35, 1'b0, 1'b1, 0);
    add(1'b0, 35, 1'b0, 1'b1, 1);
    add(1'b0, 35, 1'b0, 1'b1, 6);
    add(1'b0, 35, 1'b0, 1'b0, 7);
    add(1'b0, 35, 1'b0, 1'b0, 7);
    add(1'b0, 35, 1'b0, 1'b1, 7);
    add(1'b0, 35, 1'b0, 1'b1, 8);
    add(1'b0, 0, 1'b0, 1'b0, 0);
    run_all();
    check("retired_after_lw_wait", retired, 5);

    // beq taken, bne not taken, jump, remaining I-type ALU ops, sw with one wait.
    add_seq(4,  1'b1, '{0, 1, 10});
    add_seq(5,  1'b1, '{0, 1, 10});
    add_seq(5,  1'b0, '{0, 1, 10});
    add_seq(2,  1'b0, '{0, 1, 11});
    add_seq(9,  1'b0, '{0, 1, 4, 5});
    add_seq(13, 1'b0, '{0, 1, 4, 5});
    add_seq(15, 1'b0, '{0, 1, 4, 5});
    add_seq(43, 1'b0, '{0, 1, 6});
    add(1'b0, 43, 1'b0, 1'b0, 9);
    add(1'b0, 43, 1'b0, 1'b1, 9);
    add(1'b0, 0, 1'b0, 1'b0, 0);
    run_all();
    check("retired_after_br_j_i", retired, 13);
    check("illcnt_after_br_j_i", ill_cnt, 0);

    // Reset held 2 cycles in the middle of a stalled MEM_READ.
    add(1'b0, 35, 1'b0, 1'b1, 0);
    add(1'b0, 35, 1'b0, 1'b1, 1);
    add(1'b0, 35, 1'b0, 1'b0, 6);
    add(1'b0, 35, 1'b0, 1'b0, 7);
    add(1'b0, 35, 1'b0, 1'b0, 7);
    add(1'b1, 35, 1'b0, 1'b0, 7);
    add(1'b1, 35, 1'b0, 1'b0, 0);
    add(1'b0, 35, 1'b0, 1'b0, 0);
    run_all();
    check("retired_after_rst", retired, 0);
    check("illcnt_after_rst", ill_cnt, 0);
    check("d2_retired_after_rst", 32'(d2_retired), 0);
    check("d2_illcnt_after_rst", 32'(d2_ill_cnt), 0);

    // Opcode 63 is illegal on both; opcode 2 jumps on dut, is illegal on dut2.
    d2_pulses = 0;
    add_seq(63, 1'b0, '{0, 1, 12});
    add_seq(2,  1'b0, '{0, 1, 11});
    add(1'b0, 0, 1'b0, 1'b0, 0);
    run_all();
    check("illcnt_dut", ill_cnt, 1);
    check("retired_dut_jump", retired, 1);
    check("d2_illegal_pulses", 32'(d2_pulses), 2);
    check("d2_illcnt", 32'(d2_ill_cnt), 2);
    check("d2_retired_unchanged", 32'(d2_retired), 0);
    check("d2_state_fetch", 32'(d2_st), 0);

    // 16 R-type instructions from reset: the 4-bit counter on dut2 wraps to 0.
    add(1'b1, 0, 1'b0, 1'b0, 0);
    add(1'b0, 0, 1'b0, 1'b0, 0);
    run_all();
    for (int i = 0; i < 16; i++) begin
      add(1'b0, 0, 1'b0, 1'b1, 0);
      run_all();
      check($sformatf("d2_retired_wrap%0d", i), 32'(d2_retired), i % 16);
      add_seq(0, 1'b0, '{1, 2, 3});
      run_all();
    end
    add(1'b0, 0, 1'b0, 1'b0, 0);
    run_all();
    check("d2_retired_wrapped", 32'(d2_retired), 0);
    check("retired_dut_16", retired, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
